tristate_bus_arbiter: RTL
=========================

# tristate_bus_arbiter

- Round-robin arbiter that generates the output enables for a shared tristate bus with three drivers.
- Each `oe[i]` feeds the enable of driver *i* on the bus downstream.
- Guarantees the bus is never driven by more than one source:
  - `oe` is always one-hot or zero.
  - A break-before-make gap separates any two grants.
  - A hold limit stops any single requester from starving the others.

## Interface

Parameters
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner keeps `oe` asserted; legal range 1..255.
- `DEAD_CYCLES`, default 1: number of all-zero `oe` cycles after every release; legal range 1..15.

Ports
- `CLOCK`  in  1  single system clock; all state changes on its rising edge.
- `RESET_N`  in  1  synchronous, active-low reset.
- `req`  in  3  per-driver bus request, level-sensitive; bit *i* = driver *i*.
- `oe`  out  3  output enables to the tristate drivers; one-hot or 3'b000.
- `grant_valid`  out  1  high exactly when `oe != 0`.
- `grant_id`  out  2  index of the current owner; 2'd0 when `grant_valid` is 0.
- `timeout`  out  1  one-cycle pulse in the cycle after a grant is revoked by `MAX_HOLD`.

## Operation

- All outputs are registered. There is no combinational path from `req` to `oe`.
- Reset values: `oe` = 3'b000, `grant_valid` = 0, `grant_id` = 0, `timeout` = 0, state = IDLE, `last` = 2 (so requester 0 has top priority after reset).
- States: IDLE, GRANT, GAP.
- IDLE:
  - If `req != 0`: pick the winner, set `owner` = winner, `oe` = onehot(winner), `hold_cnt` = 0, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, evaluated each edge:
  - Release if `req[owner]` = 0, or if `hold_cnt` = `MAX_HOLD`-1 (timeout).
  - On release: `oe` = 0, `last` = `owner`, `gap_cnt` = 0, go to GAP. Assert `timeout` only when the release was caused by the hold limit. If both conditions hit on the same edge, the release counts as a timeout.
  - Otherwise: `hold_cnt`++.
- GAP:
  - `oe` stays 0 for exactly `DEAD_CYCLES` cycles.
  - On the edge ending the last gap cycle (`gap_cnt` = `DEAD_CYCLES`-1), apply the IDLE decision directly: grant if any request is present, else go to IDLE.
  - Otherwise: `gap_cnt`++.
- Winner selection: first set bit of `req` scanning `last+1`, `last+2`, `last+3` (mod 3).
  - The previous owner gets lowest priority.
  - The previous owner may be re-granted if it is the only requester.
- Requests that arrive or drop during GAP are only sampled at the gap-end edge.
- Counters:
  - `hold_cnt` is 8 bits and `gap_cnt` is 4 bits.
  - Neither counter exceeds its limit, so no wrap-around occurs.
- Reset asserted mid-grant or mid-gap: outputs and state return to their reset values at that edge, with no gap enforced. `oe` is already 0 after the reset edge, so the bus is safe.

## Timing

- Grant latency: `req` rising and sampled at edge k gives `oe` high from edge k (visible cycle k+1), when the arbiter is in IDLE.
- Release latency: `req[owner]` sampled low at edge m gives `oe` = 0 after edge m.
- Maximum tenure: `oe` stays high for exactly `MAX_HOLD` cycles.
- Owner-to-owner turnaround: exactly `DEAD_CYCLES` cycles with `oe` = 0.
- `timeout` is high for the single cycle in which `oe` first reads 0 after a hold-limit release.
- Under continuous requests from all three drivers, the period per owner is `MAX_HOLD` + `DEAD_CYCLES`.

## Structure

- Package `tristate_bus_pkg` holds:
  - `arb_state_t` enum {IDLE, GRANT, GAP}
  - `localparam N_DRV = 3`
  - function `onehot3(logic [1:0])` returning `logic [2:0]`
- Sub-module `rr_pick`:
  - Purely combinational.
  - Inputs: `req[2:0]`, `last[1:0]`.
  - Outputs: `any`, `winner[1:0]`.
  - Instantiated once.
- The arbiter holds the FSM, the two counters, and the output registers.

## Test plan

All scenarios use `MAX_HOLD` = 8 and `DEAD_CYCLES` = 1 unless a scenario says otherwise.

1. Reset: `RESET_N` = 0 for 2 edges with `req` = 3'b111 → `oe` = 000 and `grant_valid` = 0 throughout; the first edge after release → `oe` = 001, `grant_id` = 0.
2. Single requester: `req` = 010 sampled at edge 5, dropped and sampled at edge 9 → `oe` = 010 for cycles 6–9, then 000 and stays 000; `timeout` never pulses.
3. Saturation: `req` = 111 held → `oe` sequence 001×8, 000, 010×8, 000, 100×8, 000, 001…; `timeout` pulses in each 000 cycle.
4. Early release: `req` = 011 with requester 0 dropping after 3 granted cycles → `oe` 001×3, 000×1, then 010; `timeout` stays 0.
5. Reset mid-grant: `RESET_N` low on the 4th cycle of owner 1 with `req` = 111 → `oe` = 000 at that edge; after release, owner 0 is granted first.
6. Parameter variant `DEAD_CYCLES` = 3, `MAX_HOLD` = 1, random `req` over 10k cycles. The checker must see:
   - `oe` always one-hot or zero.
   - At least 3 zero cycles between any two grants.
   - No requester waits more than 2×(1+3) cycles while continuously requesting.

Source files
------------

// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and helpers for the tristate bus arbiter.
//   arb_state_t : FSM states (IDLE, GRANT, GAP)
//   N_DRV       : number of tristate drivers on the bus
//   onehot3()   : driver index -> output-enable pattern
package tristate_bus_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;

  localparam int N_DRV = 3;

  function automatic logic [N_DRV-1:0] onehot3(input logic [1:0] idx);
    logic [N_DRV-1:0] v;
    case (idx)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Bus-side signal bundle for the arbiter.
//   req         : per-driver level request
//   oe          : output enables, one-hot or zero
//   grant_valid : oe != 0
//   grant_id    : current owner, 0 when idle
//   timeout     : one-cycle pulse after a hold-limit release
// master = arbiter side, slave = requester / bus side.
interface tristate_bus_arbiter_if;
  import tristate_bus_pkg::*;

  logic [N_DRV-1:0] req;
  logic [N_DRV-1:0] oe;
  logic             grant_valid;
  logic [1:0]       grant_id;
  logic             timeout;

  modport master (input req, output oe, grant_valid, grant_id, timeout);
  modport slave  (output req, input oe, grant_valid, grant_id, timeout);
endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin pick over three requesters.
//   i_req    : request vector
//   i_last   : previous owner (lowest priority this round)
//   o_any    : at least one request present
//   o_winner : first requester found scanning last+1, last+2, last+3 (mod 3)
module rr_pick
  import tristate_bus_pkg::*;
(
  input  logic [N_DRV-1:0] i_req,
  input  logic [1:0]       i_last,
  output logic             o_any,
  output logic [1:0]       o_winner
);

  always_comb begin
    o_any    = |i_req;
    o_winner = 2'd0;
    case (i_last)
      2'd0: begin
        if      (i_req[1]) o_winner = 2'd1;
        else if (i_req[2]) o_winner = 2'd2;
        else               o_winner = 2'd0;
      end
      2'd1: begin
        if      (i_req[2]) o_winner = 2'd2;
        else if (i_req[0]) o_winner = 2'd0;
        else               o_winner = 2'd1;
      end
      default: begin
        if      (i_req[0]) o_winner = 2'd0;
        else if (i_req[1]) o_winner = 2'd1;
        else               o_winner = 2'd2;
      end
    endcase
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin output-enable arbiter for a three-driver tristate bus.
// Guarantees oe is one-hot or zero, inserts DEAD_CYCLES all-zero cycles after
// every release (break-before-make), and revokes a grant after MAX_HOLD cycles.
// All outputs are registered.
//   CLOCK   : system clock, rising edge
//   RESET_N : synchronous active-low reset
//   bus     : req in; oe, grant_valid, grant_id, timeout out
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int MAX_HOLD    = 8,  // 1..255
  parameter int DEAD_CYCLES = 1   // 1..15
) (
  input  logic                         CLOCK,
  input  logic                         RESET_N,
  tristate_bus_arbiter_if.master       bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] GAP_LAST  = 4'(DEAD_CYCLES - 1);

  arb_state_t       r_state;
  logic [1:0]       r_owner;
  logic [1:0]       r_last;
  logic [7:0]       r_hold_cnt;
  logic [3:0]       r_gap_cnt;
  logic [N_DRV-1:0] r_oe;
  logic             r_grant_valid;
  logic             r_timeout;

  logic             w_any;
  logic [1:0]       w_winner;
  logic             w_start;
  logic             w_owner_req;
  logic             w_hold_max;

  rr_pick u_pick (
    .i_req    (bus.req),
    .i_last   (r_last),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  // The gap-end edge makes the same decision as IDLE, so both share w_start.
  assign w_start     = w_any && ((r_state == IDLE) ||
                                 ((r_state == GAP) && (r_gap_cnt == GAP_LAST)));
  // r_oe is one-hot on the owner during GRANT, so masking picks req[owner].
  assign w_owner_req = |(bus.req & r_oe);
  assign w_hold_max  = (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_state       <= IDLE;
      r_owner       <= 2'd0;
      r_last        <= 2'd2;
      r_hold_cnt    <= 8'd0;
      r_gap_cnt     <= 4'd0;
      r_oe          <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (w_start) begin
        r_state       <= GRANT;
        r_owner       <= w_winner;
        r_oe          <= onehot3(w_winner);
        r_grant_valid <= 1'b1;
        r_hold_cnt    <= 8'd0;
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          GRANT: begin
            // Hold limit wins over a simultaneous request drop.
            if (!w_owner_req || w_hold_max) begin
              r_state       <= GAP;
              r_last        <= r_owner;
              r_owner       <= 2'd0;
              r_oe          <= '0;
              r_grant_valid <= 1'b0;
              r_gap_cnt     <= 4'd0;
              r_timeout     <= w_hold_max;
            end else begin
              r_hold_cnt <= r_hold_cnt + 8'd1;
            end
          end
          GAP: begin
            if (r_gap_cnt == GAP_LAST) r_state   <= IDLE;
            else                       r_gap_cnt <= r_gap_cnt + 4'd1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.oe          = r_oe;
  assign bus.grant_valid = r_grant_valid;
  assign bus.grant_id    = r_owner;
  assign bus.timeout     = r_timeout;

endmodule
